// File: rtl/register_file_32x32.sv
// 32 x 32-bit register file: one synchronous write port, two registered
// read ports. Each read port selects its source through a MUX32_32x1.
// A request with READ and WRITE both high is ignored.

// 32-input, 32-bit wide selector used by both read ports.
module MUX32_32x1 (
    input  logic [31:0] I0,
    input  logic [31:0] I1,
    input  logic [31:0] I2,
    input  logic [31:0] I3,
    input  logic [31:0] I4,
    input  logic [31:0] I5,
    input  logic [31:0] I6,
    input  logic [31:0] I7,
    input  logic [31:0] I8,
    input  logic [31:0] I9,
    input  logic [31:0] I10,
    input  logic [31:0] I11,
    input  logic [31:0] I12,
    input  logic [31:0] I13,
    input  logic [31:0] I14,
    input  logic [31:0] I15,
    input  logic [31:0] I16,
    input  logic [31:0] I17,
    input  logic [31:0] I18,
    input  logic [31:0] I19,
    input  logic [31:0] I20,
    input  logic [31:0] I21,
    input  logic [31:0] I22,
    input  logic [31:0] I23,
    input  logic [31:0] I24,
    input  logic [31:0] I25,
    input  logic [31:0] I26,
    input  logic [31:0] I27,
    input  logic [31:0] I28,
    input  logic [31:0] I29,
    input  logic [31:0] I30,
    input  logic [31:0] I31,
    input  logic [4:0]  S,
    output logic [31:0] Y
);

    // Route the selected input to the output.
    always_comb begin
        Y = I0;
        case (S)
            5'd0:  Y = I0;
            5'd1:  Y = I1;
            5'd2:  Y = I2;
            5'd3:  Y = I3;
            5'd4:  Y = I4;
            5'd5:  Y = I5;
            5'd6:  Y = I6;
            5'd7:  Y = I7;
            5'd8:  Y = I8;
            5'd9:  Y = I9;
            5'd10: Y = I10;
            5'd11: Y = I11;
            5'd12: Y = I12;
            5'd13: Y = I13;
            5'd14: Y = I14;
            5'd15: Y = I15;
            5'd16: Y = I16;
            5'd17: Y = I17;
            5'd18: Y = I18;
            5'd19: Y = I19;
            5'd20: Y = I20;
            5'd21: Y = I21;
            5'd22: Y = I22;
            5'd23: Y = I23;
            5'd24: Y = I24;
            5'd25: Y = I25;
            5'd26: Y = I26;
            5'd27: Y = I27;
            5'd28: Y = I28;
            5'd29: Y = I29;
            5'd30: Y = I30;
            5'd31: Y = I31;
            default: Y = I0;
        endcase
    end

endmodule

module register_file_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [4:0]            ADDR_R1,
    input  logic [4:0]            ADDR_R2,
    input  logic [4:0]            ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  RD_VALID
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_COUNT-1:0]  write_en;
    logic                  write_ok;
    logic                  read_ok;
    logic [DATA_WIDTH-1:0] mux_r1;
    logic [DATA_WIDTH-1:0] mux_r2;

    // Simultaneous READ and WRITE is illegal and decodes to idle.
    assign write_ok = WRITE & ~READ;
    assign read_ok  = READ & ~WRITE;

    // One-hot write-enable decode of the write address.
    always_comb begin
        write_en = '0;
        if (write_ok) begin
            write_en[ADDR_W] = 1'b1;
        end
    end

    // Register storage; async clear, per-entry write enable.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (write_en[i]) begin
                    regs[i] <= DATA_W;
                end
            end
        end
    end

    MUX32_32x1 u_mux_r1 (
        .I0 (regs[0]),  .I1 (regs[1]),  .I2 (regs[2]),  .I3 (regs[3]),
        .I4 (regs[4]),  .I5 (regs[5]),  .I6 (regs[6]),  .I7 (regs[7]),
        .I8 (regs[8]),  .I9 (regs[9]),  .I10(regs[10]), .I11(regs[11]),
        .I12(regs[12]), .I13(regs[13]), .I14(regs[14]), .I15(regs[15]),
        .I16(regs[16]), .I17(regs[17]), .I18(regs[18]), .I19(regs[19]),
        .I20(regs[20]), .I21(regs[21]), .I22(regs[22]), .I23(regs[23]),
        .I24(regs[24]), .I25(regs[25]), .I26(regs[26]), .I27(regs[27]),
        .I28(regs[28]), .I29(regs[29]), .I30(regs[30]), .I31(regs[31]),
        .S  (ADDR_R1),
        .Y  (mux_r1)
    );

    MUX32_32x1 u_mux_r2 (
        .I0 (regs[0]),  .I1 (regs[1]),  .I2 (regs[2]),  .I3 (regs[3]),
        .I4 (regs[4]),  .I5 (regs[5]),  .I6 (regs[6]),  .I7 (regs[7]),
        .I8 (regs[8]),  .I9 (regs[9]),  .I10(regs[10]), .I11(regs[11]),
        .I12(regs[12]), .I13(regs[13]), .I14(regs[14]), .I15(regs[15]),
        .I16(regs[16]), .I17(regs[17]), .I18(regs[18]), .I19(regs[19]),
        .I20(regs[20]), .I21(regs[21]), .I22(regs[22]), .I23(regs[23]),
        .I24(regs[24]), .I25(regs[25]), .I26(regs[26]), .I27(regs[27]),
        .I28(regs[28]), .I29(regs[29]), .I30(regs[30]), .I31(regs[31]),
        .S  (ADDR_R2),
        .Y  (mux_r2)
    );

    // Read output registers: capture pre-edge contents on a legal read, else hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DATA_R1 <= '0;
            DATA_R2 <= '0;
        end else if (read_ok) begin
            DATA_R1 <= mux_r1;
            DATA_R2 <= mux_r2;
        end
    end

    // RD_VALID pulses for exactly the cycle following each legal read.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RD_VALID <= 1'b0;
        end else begin
            RD_VALID <= read_ok;
        end
    end

endmodule

// File: tb/tb_register_file_32x32.sv
// Scoreboard bench for register_file_32x32: a bench-side register model
// pushes expected read pairs at stimulus time; they are popped and compared
// after the DUT's capture edge.
module tb_register_file_32x32;

    logic        clk;
    logic        rst;
    logic        read;
    logic        write;
    logic [4:0]  addr_r1;
    logic [4:0]  addr_r2;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic [31:0] data_r1;
    logic [31:0] data_r2;
    logic        rd_valid;

    int vectors;
    int miscompares;

    logic [31:0] mreg [32];
    logic [31:0] mout1;
    logic [31:0] mout2;
    logic        exp_valid;
    logic [63:0] exp_q [$];

    register_file_32x32 dut (
        .CLK     (clk),
        .RST     (rst),
        .READ    (read),
        .WRITE   (write),
        .ADDR_R1 (addr_r1),
        .ADDR_R2 (addr_r2),
        .ADDR_W  (addr_w),
        .DATA_W  (data_w),
        .DATA_R1 (data_r1),
        .DATA_R2 (data_r2),
        .RD_VALID(rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        mout1 = '0;
        mout2 = '0;
        exp_q.delete();
    endtask

    // Drive one request on the falling edge, check results just after the rising edge.
    task automatic apply(input string tag, input logic rd, input logic wr,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] aw, input logic [31:0] dw);
        logic [63:0] pair;
        @(negedge clk);
        read = rd; write = wr; addr_r1 = a1; addr_r2 = a2; addr_w = aw; data_w = dw;
        exp_valid = rd && !wr;
        if (exp_valid) exp_q.push_back({mreg[a1], mreg[a2]});
        if (wr && !rd) mreg[aw] = dw;
        @(posedge clk);
        #1;
        check({tag, ".rd_valid"}, {31'd0, rd_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            if (exp_q.size() == 0) begin
                check({tag, ".queue"}, 32'd0, 32'd1);
            end else begin
                pair  = exp_q.pop_front();
                mout1 = pair[63:32];
                mout2 = pair[31:0];
            end
        end
        check({tag, ".data_r1"}, data_r1, mout1);
        check({tag, ".data_r2"}, data_r2, mout2);
    endtask

    task automatic idle(input string tag);
        apply(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; read = 1'b0; write = 1'b0;
        addr_r1 = '0; addr_r2 = '0; addr_w = '0; data_w = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset.data_r1", data_r1, 32'd0);
        check("reset.data_r2", data_r2, 32'd0);
        check("reset.rd_valid", {31'd0, rd_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Write/read all registers, reading pairs (i, 31-i).
        for (int i = 0; i < 32; i++)
            apply("wr_all", 1'b0, 1'b1, 5'd0, 5'd0, 5'(i), 32'h100 + 32'(i));
        for (int i = 0; i < 32; i++) begin
            apply("rd_pair", 1'b1, 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'd0);
            check("rd_pair.r1_abs", data_r1, 32'h100 + 32'(i));
            check("rd_pair.r2_abs", data_r2, 32'h11F - 32'(i));
            idle("rd_pair_idle");
        end

        // Back-to-back write then read of the same register.
        apply("b2b_wr", 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h12345678);
        apply("b2b_rd", 1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 32'd0);
        check("b2b.abs", data_r1, 32'h12345678);

        // Illegal READ=WRITE=1 leaves storage and outputs untouched.
        apply("ill_prep", 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'hA5A5A5A5);
        apply("ill_rd0", 1'b1, 1'b0, 5'd7, 5'd10, 5'd0, 32'd0);
        apply("illegal", 1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 32'hFFFFFFFF);
        apply("ill_chk", 1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 32'd0);
        check("ill.r3_abs", data_r1, 32'hA5A5A5A5);

        // Outputs hold across idles and writes until the next read.
        apply("hold_w1", 1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 32'h11);
        apply("hold_w2", 1'b0, 1'b1, 5'd0, 5'd0, 5'd2, 32'h22);
        apply("hold_rd", 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0);
        for (int i = 0; i < 10; i++) idle("hold_idle");
        apply("hold_w99", 1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 32'h99);
        check("hold.r1_abs", data_r1, 32'h11);
        check("hold.r2_abs", data_r2, 32'h22);
        apply("hold_rd2", 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0);

        // Boundary addresses.
        apply("bnd_w31", 1'b0, 1'b1, 5'd0, 5'd0, 5'd31, 32'h80000001);
        apply("bnd_w0", 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h7FFFFFFE);
        apply("bnd_rd", 1'b1, 1'b0, 5'd31, 5'd0, 5'd0, 32'd0);
        check("bnd.r1_abs", data_r1, 32'h80000001);
        check("bnd.r2_abs", data_r2, 32'h7FFFFFFE);

        // Random mix against the model.
        for (int i = 0; i < 300; i++)
            apply("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), $urandom());

        // Asynchronous reset mid-cycle, after R5 written and read.
        apply("rst_w5", 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF);
        apply("rst_rd5", 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'd0);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.data_r1", data_r1, 32'd0);
        check("async_rst.data_r2", data_r2, 32'd0);
        check("async_rst.rd_valid", {31'd0, rd_valid}, 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        apply("post_rst_rd5", 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'd0);
        check("post_rst.r5_abs", data_r1, 32'd0);
        idle("end_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
